count_cmd_scheduler: RTL
========================

Name: count_cmd_scheduler

Overview:
- Shares one WIDTH-bit up/down counter (load/up/down/data_in control, count feedback) among NREQ command requesters.
- Round-robin arbitration; each accepted command (LOAD, UP-by-N, DOWN-by-N, NOP) is sequenced as per-cycle control pulses to the counter.
- Optional saturation stops UP/DOWN runs at the counter limits.
- Reports completion per command. Sits between requester logic and the counter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter width.
- REP_W, 4, width of repeat field; steps = rep+1 (1..2^REP_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_op  in  2*NREQ  packed op per requester: 00 NOP, 01 LOAD, 10 UP, 11 DOWN
- req_data  in  WIDTH*NREQ  packed LOAD value
- req_rep  in  REP_W*NREQ  packed repeat field
- sat_en  in  1  1 = saturate at 0 / 2^WIDTH-1; 0 = wrap
- cnt_value  in  WIDTH  current counter output
- cnt_load  out  1  counter load strobe
- cnt_up  out  1  counter increment strobe
- cnt_down  out  1  counter decrement strobe
- cnt_data  out  WIDTH  counter load data
- busy  out  1  high in EXEC and DONE
- done_valid  out  1  one-cycle completion pulse
- done_id  out  $clog2(NREQ)  requester index of completed command
- done_sat  out  1  completed command ended early on saturation

Behaviour:
- Reset values: FSM IDLE, rr pointer 0, req_ready 0, cnt_load/up/down 0, cnt_data 0, busy 0, done_valid 0, done_id 0, done_sat 0. Reset mid-command aborts it; no done pulse is issued.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - If any req_valid is high, the winner is the first valid index at or after the rr pointer, searched cyclically.
  - req_ready[winner] is asserted combinationally in the same cycle; the handshake completes at that edge.
  - op, data, rep and winner id are latched. Next state is EXEC, or DONE when op is NOP.
- Requester rules: a requester holds valid, op, data and rep stable until ready. Ready is never asserted in EXEC or DONE, or to a non-valid requester.
- EXEC, LOAD: one cycle with cnt_load=1 and cnt_data=latched data, then DONE.
- EXEC, UP/DOWN:
  - A remaining-step counter is initialised to rep+1.
  - Each EXEC cycle asserts exactly one of cnt_up or cnt_down and decrements the remaining count. Leave EXEC after the last step.
  - cnt_value in cycle k reflects all pulses issued before cycle k. The saturation check uses that value.
- Saturation (sat_en=1):
  - If UP and cnt_value == 2^WIDTH-1, or DOWN and cnt_value == 0, suppress the pulse, set the sat flag and go to DONE immediately.
  - A run that starts at the limit issues zero pulses.
- Wrap (sat_en=0): pulses are always issued and the counter wraps (15->0, 0->15).
- cnt_data equals the latched data whenever cnt_load=1, and is 0 otherwise.
- DONE: done_valid=1 for one cycle, with done_id and done_sat valid. rr pointer becomes (winner+1) mod NREQ. Next state is IDLE.
- Latency:
  - Accept cycle to first counter strobe: 1 cycle.
  - Total accept to done_valid: 1 + steps cycles (LOAD: steps=1; NOP: 0 steps).
  - Next accept is earliest in the cycle after DONE.
- sat_en is sampled every EXEC cycle; changing it mid-run takes effect on the next step.
- At most one of cnt_load/cnt_up/cnt_down is high in any cycle (assertion).

Decomposition:
- Package count_sched_pkg holds the op encodings (OP_NOP, OP_LOAD, OP_UP, OP_DOWN), the state enum (IDLE, EXEC, DONE) and the function count_max(WIDTH).
- Sub-module rr_arbiter (NREQ): inputs are the request vector and pointer; outputs are the one-hot grant and binary index. It is purely combinational; the pointer register stays in the scheduler.

Test Plan:
- Reset, then req0 LOAD data=9 -> req_ready[0] one cycle, cnt_load=1 with cnt_data=9 next cycle, done_valid with done_id=0 and done_sat=0 one cycle later; counter reads 9.
- Counter=3, req1 UP rep=4, sat_en=0 -> 5 consecutive cnt_up cycles, counter=8, done_id=1, accept-to-done latency 6 cycles.
- Counter=13, req2 UP rep=7, sat_en=1 -> 2 cnt_up pulses, counter holds 15, done_sat=1. Repeat with sat_en=0 -> 8 pulses, counter=5 (wrapped).
- Counter=0, DOWN rep=0, sat_en=1 -> no cnt_down, done_sat=1 immediately. With sat_en=0 -> one pulse, counter=15.
- All four requesters valid continuously with NOPs -> grant order 0,1,2,3,0; each NOP takes 2 cycles (accept, done); no requester is granted twice before the others.
- reset asserted during the 3rd step of an UP rep=9 run -> all outputs 0 asynchronously, no done_valid. After release, req3 and req0 valid together -> req0 is granted first (pointer back at 0).

Source files
------------

// File: rtl/count_sched_pkg.sv
// ----------------------------------------------------------------------------
// count_sched_pkg
// Shared definitions for the counter command scheduler:
//   op_e      - command encodings carried on req_op (NOP / LOAD / UP / DOWN)
//   state_e   - scheduler FSM states (IDLE / EXEC / DONE)
//   count_max - all-ones value of a counter of the given width (saturation top)
// ----------------------------------------------------------------------------
package count_sched_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_UP   = 2'b10,
      OP_DOWN = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Largest value an unsigned counter of 'width' bits can hold.
   function automatic logic [63:0] count_max(input int unsigned width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage : count_sched_pkg

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first asserted
// request at or after 'ptr', searching cyclically. The pointer register
// lives in the parent.
// Ports:
//   req   in  NREQ          request vector
//   ptr   in  $clog2(NREQ)  highest-priority index for this pick
//   grant out NREQ          one-hot grant (zero when no request)
//   idx   out $clog2(NREQ)  binary index of the grant (0 when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx
);

   localparam int IDW = $clog2(NREQ);

   always_comb begin
      // NOTE: every output gets a default before the search loop, so no path
      // leaves a value unassigned and no latch is inferred.
      logic found;
      int   j;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr) + i) % NREQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/count_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// count_cmd_scheduler
// Shares one up/down counter among NREQ requesters. A round-robin winner is
// accepted in IDLE, its command is played out as per-cycle load/up/down
// strobes in EXEC, and a one-cycle completion report is given in DONE.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_op              packed 2-bit op per requester (NOP/LOAD/UP/DOWN)
//   req_data            packed LOAD value per requester
//   req_rep             packed repeat field per requester (steps = rep+1)
//   sat_en              1 = stop UP/DOWN runs at the limits, 0 = wrap
//   cnt_value           counter output fed back for the saturation check
//   cnt_load/up/down    counter control strobes (at most one high)
//   cnt_data            counter load data (0 unless cnt_load)
//   busy                high in EXEC and DONE
//   done_valid/id/sat   completion pulse, requester index, early-stop flag
// ----------------------------------------------------------------------------
module count_cmd_scheduler
   import count_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int REP_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_data,
   input  logic [REP_W*NREQ-1:0]   req_rep,
   input  logic                    sat_en,
   input  logic [WIDTH-1:0]        cnt_value,
   output logic                    cnt_load,
   output logic                    cnt_up,
   output logic                    cnt_down,
   output logic [WIDTH-1:0]        cnt_data,
   output logic                    busy,
   output logic                    done_valid,
   output logic [$clog2(NREQ)-1:0] done_id,
   output logic                    done_sat
);

   localparam int IDW = $clog2(NREQ);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(count_max(WIDTH));

   state_e             state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q;
   logic [IDW-1:0]     id_q;
   op_e                op_q;
   logic [WIDTH-1:0]   data_q;
   logic [REP_W:0]     rem_q;    // steps still to issue; one bit wider to hold 2^REP_W
   logic               sat_q;

   logic [NREQ-1:0]    win_grant;
   logic [IDW-1:0]     win_idx;
   op_e                win_op;
   logic [WIDTH-1:0]   win_data;
   logic [REP_W-1:0]   win_rep;
   logic               accept;
   logic               hit_limit;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (win_grant),
      .idx   (win_idx)
   );

   // Fields of the current winner, extracted from the packed request buses.
   assign win_op   = op_e'(req_op[int'(win_idx)*2 +: 2]);
   assign win_data = req_data[int'(win_idx)*WIDTH +: WIDTH];
   assign win_rep  = req_rep[int'(win_idx)*REP_W +: REP_W];

   // Handshake completes at the edge closing an IDLE cycle with any valid.
   // Ready is held low while reset is asserted so nothing looks accepted.
   assign accept = (state_q == IDLE) && (|req_valid) && !reset;

   // cnt_value already reflects every pulse issued before this cycle, so a
   // run is stopped before it would step past a limit.
   assign hit_limit = sat_en &&
                      (((op_q == OP_UP)   && (cnt_value == CNT_MAX)) ||
                       ((op_q == OP_DOWN) && (cnt_value == '0)));

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = (win_op == OP_NOP) ? DONE : EXEC;
         end
         EXEC: begin
            if (op_q == OP_UP || op_q == OP_DOWN) begin
               if (hit_limit || rem_q == (REP_W+1)'(1)) state_d = DONE;
            end else begin
               state_d = DONE;   // LOAD is a single cycle
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      req_ready  = accept ? win_grant : '0;
      cnt_load   = 1'b0;
      cnt_up     = 1'b0;
      cnt_down   = 1'b0;
      cnt_data   = '0;
      busy       = (state_q != IDLE);
      done_valid = (state_q == DONE);
      done_id    = (state_q == DONE) ? id_q  : '0;
      done_sat   = (state_q == DONE) ? sat_q : 1'b0;
      if (state_q == EXEC) begin
         unique case (op_q)
            OP_LOAD: begin
               cnt_load = 1'b1;
               cnt_data = data_q;
            end
            OP_UP:   cnt_up   = !hit_limit;
            OP_DOWN: cnt_down = !hit_limit;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         id_q     <= '0;
         op_q     <= OP_NOP;
         data_q   <= '0;
         rem_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  id_q   <= win_idx;
                  op_q   <= win_op;
                  data_q <= win_data;
                  rem_q  <= {1'b0, win_rep} + (REP_W+1)'(1);
                  sat_q  <= 1'b0;
               end
            end
            EXEC: begin
               if (op_q == OP_UP || op_q == OP_DOWN) begin
                  if (hit_limit) sat_q <= 1'b1;
                  else           rem_q <= rem_q - (REP_W+1)'(1);
               end
            end
            DONE: begin
               rr_ptr_q <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
            end
            default: ;
         endcase
      end
   end

   // The counter must never see two control strobes in the same cycle.
   a_one_strobe: assert property (@(posedge clk) disable iff (reset)
                                  $onehot0({cnt_load, cnt_up, cnt_down}));

endmodule : count_cmd_scheduler
